// File: rtl/bsg_dfi_fifo_bridge.sv
// Single-clock DFI to valid/ready FIFO bridge: one FIFO beat per DFI beat group,
// delayed read-data-enable, outstanding-read tracking and sticky channel errors.
module bsg_dfi_fifo_bridge #(
    parameter int clk_ratio_p          = 2,
    parameter int dq_data_width_p      = 32,
    parameter int rd_latency_p         = 2,
    parameter int max_rd_outstanding_p = 8,
    localparam int dq_group_lp         = dq_data_width_p / 8
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,

    input  logic [2:0]                                 dfi_bank_i,
    input  logic [15:0]                                dfi_address_i,
    input  logic                                       dfi_cke_i,
    input  logic                                       dfi_cs_n_i,
    input  logic                                       dfi_ras_n_i,
    input  logic                                       dfi_cas_n_i,
    input  logic                                       dfi_we_n_i,
    input  logic                                       dfi_reset_n_i,
    input  logic                                       dfi_odt_i,

    input  logic                                       dfi_wrdata_en_i,
    input  logic [2*dq_data_width_p-1:0]               dfi_wrdata_i,
    input  logic [2*dq_group_lp-1:0]                   dfi_wrdata_mask_i,

    input  logic                                       dfi_rddata_en_i,
    output logic [2*dq_data_width_p-1:0]               dfi_rddata_o,
    output logic                                       dfi_rddata_valid_o,

    output logic                                       fifo_wr_v_o,
    output logic [2*dq_data_width_p+2*dq_group_lp-1:0] fifo_wr_data_o,
    input  logic                                       fifo_wr_ready_i,

    output logic                                       fifo_cmd_v_o,
    output logic [25:0]                                fifo_cmd_data_o,
    input  logic                                       fifo_cmd_ready_i,

    input  logic                                       fifo_rd_v_i,
    input  logic [2*dq_data_width_p-1:0]               fifo_rd_data_i,
    output logic                                       fifo_rd_yumi_o,

    output logic [7:0]                                 rd_outstanding_o,
    input  logic                                       error_clr_i,
    output logic [3:0]                                 error_o,
    output logic                                       fifo_error_o
);

    localparam int              phase_w_lp    = (clk_ratio_p > 1) ? $clog2(clk_ratio_p) : 1;
    localparam logic [phase_w_lp-1:0] last_phase_lp = phase_w_lp'(clk_ratio_p - 1);
    localparam logic [7:0]      max_rd_lp     = 8'(max_rd_outstanding_p);

    logic [phase_w_lp-1:0]   wr_phase_q, wr_phase_d;
    logic [phase_w_lp-1:0]   cmd_phase_q, cmd_phase_d;
    logic [phase_w_lp-1:0]   rd_phase_q, rd_phase_d;
    logic [rd_latency_p-1:0] rd_pipe_q, rd_pipe_d;
    logic [7:0]              rd_cnt_q, rd_cnt_d;
    logic [3:0]              error_q, error_d;
    logic                    rd_cmd, rd_track_err;

    // Phase counters only move while their channel is qualified.
    function automatic logic [phase_w_lp-1:0] next_phase(input logic qual,
                                                         input logic [phase_w_lp-1:0] ph);
        if (!qual) return ph;
        return (ph == last_phase_lp) ? '0 : ph + 1'b1;
    endfunction

    assign fifo_wr_v_o        = dfi_wrdata_en_i & (wr_phase_q == '0);
    assign fifo_wr_data_o     = {dfi_wrdata_i, dfi_wrdata_mask_i};
    assign fifo_cmd_v_o       = ~dfi_cs_n_i & (cmd_phase_q == '0);
    assign fifo_cmd_data_o    = {dfi_bank_i, dfi_address_i, dfi_cke_i, dfi_cs_n_i,
                                 dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i, dfi_reset_n_i, dfi_odt_i};
    assign dfi_rddata_valid_o = rd_pipe_q[rd_latency_p-1];
    assign fifo_rd_yumi_o     = dfi_rddata_valid_o & (rd_phase_q == last_phase_lp);
    assign dfi_rddata_o       = fifo_rd_data_i;
    assign rd_outstanding_o   = rd_cnt_q;
    assign error_o            = error_q;
    assign fifo_error_o       = |error_q;

    assign rd_cmd = fifo_cmd_v_o & fifo_cmd_ready_i & ~dfi_cs_n_i & dfi_ras_n_i
                  & ~dfi_cas_n_i & dfi_we_n_i;

    always_comb begin
        wr_phase_d  = next_phase(dfi_wrdata_en_i, wr_phase_q);
        cmd_phase_d = next_phase(~dfi_cs_n_i, cmd_phase_q);
        rd_phase_d  = next_phase(dfi_rddata_valid_o, rd_phase_q);
        rd_pipe_d   = (rd_pipe_q << 1) | rd_latency_p'(dfi_rddata_en_i);

        // A simultaneous command and yumi cancel, even at either bound.
        rd_cnt_d     = rd_cnt_q;
        rd_track_err = 1'b0;
        if (rd_cmd && !fifo_rd_yumi_o) begin
            if (rd_cnt_q == max_rd_lp) rd_track_err = 1'b1;
            else                       rd_cnt_d     = rd_cnt_q + 8'd1;
        end else if (!rd_cmd && fifo_rd_yumi_o) begin
            if (rd_cnt_q == 8'd0) rd_track_err = 1'b1;
            else                  rd_cnt_d     = rd_cnt_q - 8'd1;
        end

        error_d = (error_q & {4{~error_clr_i}})
                | {rd_track_err,
                   fifo_rd_yumi_o & ~fifo_rd_v_i,
                   fifo_cmd_v_o & ~fifo_cmd_ready_i,
                   fifo_wr_v_o & ~fifo_wr_ready_i};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_phase_q  <= '0;
            cmd_phase_q <= '0;
            rd_phase_q  <= '0;
            rd_pipe_q   <= '0;
            rd_cnt_q    <= '0;
            error_q     <= '0;
        end else begin
            wr_phase_q  <= wr_phase_d;
            cmd_phase_q <= cmd_phase_d;
            rd_phase_q  <= rd_phase_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_cnt_q    <= rd_cnt_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_bsg_dfi_fifo_bridge.sv
// Directed per-cycle vector table for bsg_dfi_fifo_bridge (ratio 4, latency 3, max 2 reads)
// plus hand-written reset and datapath sequences.
module tb_bsg_dfi_fifo_bridge;

    localparam int DW = 32;
    localparam int GW = DW / 8;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [2:0]        dfi_bank_i;
    logic [15:0]       dfi_address_i;
    logic              dfi_cke_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i;
    logic              dfi_reset_n_i, dfi_odt_i;
    logic              dfi_wrdata_en_i;
    logic [2*DW-1:0]   dfi_wrdata_i;
    logic [2*GW-1:0]   dfi_wrdata_mask_i;
    logic              dfi_rddata_en_i;
    logic [2*DW-1:0]   dfi_rddata_o;
    logic              dfi_rddata_valid_o;
    logic              fifo_wr_v_o;
    logic [2*DW+2*GW-1:0] fifo_wr_data_o;
    logic              fifo_wr_ready_i;
    logic              fifo_cmd_v_o;
    logic [25:0]       fifo_cmd_data_o;
    logic              fifo_cmd_ready_i;
    logic              fifo_rd_v_i;
    logic [2*DW-1:0]   fifo_rd_data_i;
    logic              fifo_rd_yumi_o;
    logic [7:0]        rd_outstanding_o;
    logic              error_clr_i;
    logic [3:0]        error_o;
    logic              fifo_error_o;

    bsg_dfi_fifo_bridge #(
        .clk_ratio_p(4), .dq_data_width_p(DW), .rd_latency_p(3), .max_rd_outstanding_p(2)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .dfi_bank_i(dfi_bank_i), .dfi_address_i(dfi_address_i), .dfi_cke_i(dfi_cke_i),
        .dfi_cs_n_i(dfi_cs_n_i), .dfi_ras_n_i(dfi_ras_n_i), .dfi_cas_n_i(dfi_cas_n_i),
        .dfi_we_n_i(dfi_we_n_i), .dfi_reset_n_i(dfi_reset_n_i), .dfi_odt_i(dfi_odt_i),
        .dfi_wrdata_en_i(dfi_wrdata_en_i), .dfi_wrdata_i(dfi_wrdata_i),
        .dfi_wrdata_mask_i(dfi_wrdata_mask_i), .dfi_rddata_en_i(dfi_rddata_en_i),
        .dfi_rddata_o(dfi_rddata_o), .dfi_rddata_valid_o(dfi_rddata_valid_o),
        .fifo_wr_v_o(fifo_wr_v_o), .fifo_wr_data_o(fifo_wr_data_o),
        .fifo_wr_ready_i(fifo_wr_ready_i), .fifo_cmd_v_o(fifo_cmd_v_o),
        .fifo_cmd_data_o(fifo_cmd_data_o), .fifo_cmd_ready_i(fifo_cmd_ready_i),
        .fifo_rd_v_i(fifo_rd_v_i), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_rd_yumi_o(fifo_rd_yumi_o), .rd_outstanding_o(rd_outstanding_o),
        .error_clr_i(error_clr_i), .error_o(error_o), .fifo_error_o(fifo_error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       wr_en, wr_rdy, cs_n, rdcmd, cmd_rdy, rd_en, rd_v, clr;
        logic       e_wr_v, e_cmd_v, e_valid, e_yumi;
        logic [3:0] e_err;
        logic [7:0] e_out;
    } vec_t;

    vec_t vec[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic wr_en, wr_rdy, cs_n, rdcmd, cmd_rdy, rd_en, rd_v, clr,
                     input logic e_wr_v, e_cmd_v, e_valid, e_yumi,
                     input logic [3:0] e_err, input logic [7:0] e_out);
        vec_t r;
        r.wr_en = wr_en; r.wr_rdy = wr_rdy; r.cs_n = cs_n; r.rdcmd = rdcmd;
        r.cmd_rdy = cmd_rdy; r.rd_en = rd_en; r.rd_v = rd_v; r.clr = clr;
        r.e_wr_v = e_wr_v; r.e_cmd_v = e_cmd_v; r.e_valid = e_valid; r.e_yumi = e_yumi;
        r.e_err = e_err; r.e_out = e_out;
        vec.push_back(r);
    endtask

    task automatic idle_inputs();
        dfi_wrdata_en_i = 0; fifo_wr_ready_i = 1; dfi_cs_n_i = 1; dfi_ras_n_i = 1;
        dfi_cas_n_i = 1; dfi_we_n_i = 1; fifo_cmd_ready_i = 1; dfi_rddata_en_i = 0;
        fifo_rd_v_i = 1; error_clr_i = 0;
    endtask

    initial begin
        reset_n_i = 0;
        dfi_bank_i = 0; dfi_address_i = 0; dfi_cke_i = 1; dfi_reset_n_i = 1; dfi_odt_i = 0;
        dfi_wrdata_i = '0; dfi_wrdata_mask_i = '0; fifo_rd_data_i = '0;
        idle_inputs();

        // Write phasing, ready high throughout
        for (int i = 0; i < 8; i++) v(1,1,1,0,1,0,1,0, (i % 4 == 0),0,0,0, 4'h0, 8'd0);
        // Write backpressure, clear, set-and-clear together
        v(1,0,1,0,1,0,1,0, 1,0,0,0, 4'h0, 8'd0);
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h1, 8'd0);
        v(0,1,1,0,1,0,1,1, 0,0,0,0, 4'h1, 8'd0);
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h0, 8'd0);
        for (int i = 0; i < 3; i++) v(1,1,1,0,1,0,1,0, 0,0,0,0, 4'h0, 8'd0);
        v(1,0,1,0,1,0,1,1, 1,0,0,0, 4'h0, 8'd0);
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h1, 8'd0);
        v(0,1,1,0,1,0,1,1, 0,0,0,0, 4'h1, 8'd0);
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h0, 8'd0);
        // Two read commands, each held for one 1x cycle
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 4; p++)
                v(0,1,0,1,1,0,1,0, 0,(p == 0),0,0, 4'h0, 8'((p == 0) ? c : c + 1));
        // Two back-to-back 4-beat reads drain the count
        for (int k = 0; k < 12; k++)
            v(0,1,1,0,1,(k < 8),1,0, 0,0,(k >= 3 && k <= 10),(k == 6 || k == 10),
              4'h0, 8'((k <= 6) ? 2 : (k <= 10) ? 1 : 0));
        // Unexpected third read: underflow
        for (int k = 0; k < 8; k++)
            v(0,1,1,0,1,(k < 4),1,0, 0,0,(k >= 3 && k <= 6),(k == 6),
              (k == 7) ? 4'h8 : 4'h0, 8'd0);
        v(0,1,1,0,1,0,1,1, 0,0,0,0, 4'h8, 8'd0);
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h0, 8'd0);
        // Three read commands against a capacity of two: saturation
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 4; p++)
                v(0,1,0,1,1,0,1,0, 0,(p == 0),0,0, (c == 2 && p > 0) ? 4'h8 : 4'h0,
                  8'((p == 0) ? ((c < 2) ? c : 2) : ((c + 1 < 2) ? c + 1 : 2)));
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h8, 8'd2);
        v(0,1,1,0,1,0,1,1, 0,0,0,0, 4'h8, 8'd2);
        v(0,1,1,0,1,0,1,0, 0,0,0,0, 4'h0, 8'd2);
        // Command accept and yumi in the same cycle at the bound
        for (int k = 0; k < 11; k++)
            v(0,1,!(k >= 6 && k <= 9),1,1,(k < 4),1,0, 0,(k == 6),(k >= 3 && k <= 6),(k == 6),
              4'h0, 8'd2);
        // Yumi with no read data available
        for (int k = 0; k < 8; k++)
            v(0,1,1,0,1,(k < 4),0,0, 0,0,(k >= 3 && k <= 6),(k == 6),
              (k == 7) ? 4'h4 : 4'h0, 8'((k <= 6) ? 2 : 1));
        // Non-read command refused
        for (int k = 0; k < 5; k++)
            v(0,1,(k == 4),0,0,0,1,0, 0,(k == 0),0,0, (k == 0) ? 4'h4 : 4'h6, 8'd1);

        // Reset state and pure datapath mapping
        #12;
        check("rst valid", dfi_rddata_valid_o, 0);
        check("rst err", error_o, 0);
        check("rst fifo_err", fifo_error_o, 0);
        check("rst outst", rd_outstanding_o, 0);
        check("rst wr_v", fifo_wr_v_o, 0);
        check("rst cmd_v", fifo_cmd_v_o, 0);
        check("rst yumi", fifo_rd_yumi_o, 0);
        dfi_wrdata_i = 64'h0123456789ABCDEF; dfi_wrdata_mask_i = 8'hA5;
        dfi_bank_i = 3'h5; dfi_address_i = 16'hBEEF; dfi_cs_n_i = 0; dfi_odt_i = 0;
        dfi_ras_n_i = 1; dfi_cas_n_i = 0; dfi_we_n_i = 1;
        fifo_rd_data_i = 64'hFEEDFACECAFEF00D;
        #1;
        check("wr_data map", fifo_wr_data_o, 72'h0123456789ABCDEFA5);
        check("cmd_data map", fifo_cmd_data_o, {3'h5, 16'hBEEF, 7'b1010110});
        check("rddata pass", dfi_rddata_o, 64'hFEEDFACECAFEF00D);
        idle_inputs();
        @(negedge clk_i);
        reset_n_i = 1;

        foreach (vec[i]) begin
            @(negedge clk_i);
            dfi_wrdata_en_i  = vec[i].wr_en;
            fifo_wr_ready_i  = vec[i].wr_rdy;
            dfi_cs_n_i       = vec[i].cs_n;
            dfi_ras_n_i      = vec[i].rdcmd;
            dfi_cas_n_i      = !vec[i].rdcmd;
            dfi_we_n_i       = 1;
            fifo_cmd_ready_i = vec[i].cmd_rdy;
            dfi_rddata_en_i  = vec[i].rd_en;
            fifo_rd_v_i      = vec[i].rd_v;
            error_clr_i      = vec[i].clr;
            #1;
            check($sformatf("row%0d wr_v", i), fifo_wr_v_o, vec[i].e_wr_v);
            check($sformatf("row%0d cmd_v", i), fifo_cmd_v_o, vec[i].e_cmd_v);
            check($sformatf("row%0d rd_valid", i), dfi_rddata_valid_o, vec[i].e_valid);
            check($sformatf("row%0d yumi", i), fifo_rd_yumi_o, vec[i].e_yumi);
            check($sformatf("row%0d error", i), error_o, vec[i].e_err);
            check($sformatf("row%0d fifo_error", i), fifo_error_o, |vec[i].e_err);
            check($sformatf("row%0d outstanding", i), rd_outstanding_o, vec[i].e_out);
        end

        // Async reset mid-burst: write phase left at 2, delay pipe full
        @(negedge clk_i);
        idle_inputs();
        dfi_wrdata_en_i = 1; dfi_rddata_en_i = 1;
        #1 check("pre wr_v phase1", fifo_wr_v_o, 0);
        @(negedge clk_i);
        dfi_wrdata_en_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        dfi_wrdata_en_i = 1;
        #1;
        check("pre wr_v phase2", fifo_wr_v_o, 0);
        check("pre valid", dfi_rddata_valid_o, 1);
        check("pre err", error_o, 4'h6);
        check("pre outst", rd_outstanding_o, 1);
        reset_n_i = 0; dfi_wrdata_en_i = 0; dfi_rddata_en_i = 0;
        #1;
        check("async valid", dfi_rddata_valid_o, 0);
        check("async yumi", fifo_rd_yumi_o, 0);
        check("async err", error_o, 0);
        check("async fifo_err", fifo_error_o, 0);
        check("async outst", rd_outstanding_o, 0);
        check("async wr_v", fifo_wr_v_o, 0);
        #1 reset_n_i = 1;
        @(negedge clk_i);
        dfi_wrdata_en_i = 1;
        #1 check("post wr_v first", fifo_wr_v_o, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            dfi_wrdata_en_i = 0;
            #1 check($sformatf("post valid%0d", k), dfi_rddata_valid_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
